// File: rtl/banked_memory.sv
// ---------------------------------------------------------------------------
// banked_memory
//
// Synchronous, fully pipelined data RAM with a request/valid interface, a
// configurable read latency, address range checking with a fault flag, and a
// memory-mapped read-only keyboard register.
//
// Address map:
//   0 .. DEPTH-1   : RAM words
//   MMIO_ADDR      : keyboard register (read-only)
//   anything else  : invalid, every access faults
//
// Ports:
//   clk        in   rising-edge clock for all state
//   reset      in   asynchronous active-high reset
//   req        in   request strobe, at most one access per cycle
//   load       in   with req: 1 = write, 0 = read
//   address    in   [ADDR_W] word address
//   in         in   [DATA_W] write data
//   kbd        in   [DATA_W] keyboard scan code, registered every cycle
//   out        out  [DATA_W] read data, holds its last value between reads
//   out_valid  out  read issued READ_LAT cycles earlier completes this cycle
//   err        out  fault for the request whose result slot is this cycle
//
// Parameters: DATA_W, ADDR_W, DEPTH, MMIO_ADDR (>= DEPTH, < 2**ADDR_W),
// READ_LAT (1..4), INIT_FILE (hex image, loaded when non-empty).
//
// Build option WRITE_FORWARD_EN:
//   defined   - RAM writes go through a one-entry registered write buffer and
//               commit one edge later; reads that hit the buffer are served
//               from it, so results are identical to the direct-write build.
//   undefined - writes land in the array at the issue edge.
// ---------------------------------------------------------------------------
module banked_memory #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 15,
    parameter int    DEPTH     = 24576,
    parameter int    MMIO_ADDR = 24576,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic [DATA_W-1:0] kbd,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              err
);

    localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] L_MMIO  = ADDR_W'(MMIO_ADDR);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_kbd;

    // Pipeline stages; index 0 is loaded at the issue edge, the last drives the outputs.
    logic [READ_LAT-1:0] r_vld;
    logic [READ_LAT-1:0] r_rd;
    logic [READ_LAT-1:0] r_er;
    logic [DATA_W-1:0]   r_dat [READ_LAT];
    logic [DATA_W-1:0]   r_out;

    logic              w_is_ram;
    logic              w_is_kbd;
    logic              w_fault;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_ram_rd;
    logic [DATA_W-1:0] w_issue_data;
    logic              w_fin_vld;
    logic              w_fin_rd;
    logic [DATA_W-1:0] w_fin_data;

    assign w_is_ram = (address < L_DEPTH);
    assign w_is_kbd = (address == L_MMIO);
    // Writes fault anywhere outside RAM; reads fault only outside RAM and KBD.
    assign w_fault  = ~w_is_ram & (load | ~w_is_kbd);
    // A write sampled while reset is high must not reach the array.
    assign w_wr_en  = req & load & w_is_ram & ~reset;

`ifdef WRITE_FORWARD_EN
    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    // Write buffer and registered RAM write port. The buffer valid is cleared
    // synchronously so a write accepted just before reset still commits.
    always_ff @(posedge clk) begin
        if (r_wb_valid) begin
            r_mem[r_wb_addr] <= r_wb_data;
        end
        r_wb_valid <= w_wr_en;
        if (w_wr_en) begin
            r_wb_addr <= address;
            r_wb_data <= in;
        end
    end

    // RAM read with forwarding from a write that has not reached the array yet.
    always_comb begin
        w_ram_rd = r_mem[address];
        if (r_wb_valid && (r_wb_addr == address)) begin
            w_ram_rd = r_wb_data;
        end else begin
            w_ram_rd = r_mem[address];
        end
    end
`else
    // Direct RAM write at the issue edge.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[address] <= in;
        end
    end

    assign w_ram_rd = r_mem[address];
`endif

    // Data captured into stage 0 for the current request.
    always_comb begin
        w_issue_data = '0;
        if (load) begin
            w_issue_data = '0;
        end else if (w_is_ram) begin
            w_issue_data = w_ram_rd;
        end else if (w_is_kbd) begin
            w_issue_data = r_kbd;
        end else begin
            w_issue_data = '0;
        end
    end

    // Value entering the last stage at the next edge; out is updated from it
    // so that out and out_valid change on the same edge.
    if (READ_LAT == 1) begin : g_fin_issue
        assign w_fin_vld  = req;
        assign w_fin_rd   = req & ~load;
        assign w_fin_data = w_issue_data;
    end else begin : g_fin_pipe
        assign w_fin_vld  = r_vld[READ_LAT-2];
        assign w_fin_rd   = r_rd[READ_LAT-2];
        assign w_fin_data = r_dat[READ_LAT-2];
    end

    // Keyboard register, request pipeline and held read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kbd <= '0;
            r_vld <= '0;
            r_rd  <= '0;
            r_er  <= '0;
            r_out <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_kbd    <= kbd;
            r_vld[0] <= req;
            r_rd[0]  <= req & ~load;
            r_er[0]  <= req & w_fault;
            r_dat[0] <= w_issue_data;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_er[i]  <= r_er[i-1];
                r_dat[i] <= r_dat[i-1];
            end
            if (w_fin_vld && w_fin_rd) begin
                r_out <= w_fin_data;
            end else begin
                r_out <= r_out;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_vld[READ_LAT-1] & r_rd[READ_LAT-1];
    assign err       = r_vld[READ_LAT-1] & r_er[READ_LAT-1];

endmodule
